mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single RAM port between instruction fetch (icache side) and data access (dcache side).
// - Sits between the pipeline's fetch/MEM-stage request ports and RAM.
// - Provides iwait/dwait back-pressure; the pipeline stalls on these alongside the hazard freeze/flush path.
// - Data side has priority; a starvation counter guarantees fetch progress.
// PARAMETERS
// ADDR_W      32  address width, bits
// DATA_W      32  data width, bits
// STARVE_MAX  4   consecutive D grants allowed while iREN is pending before I is forced
// PORTS
// CLK        in   1       rising-edge clock
// nRST       in   1       asynchronous active-low reset
// iREN       in   1       instruction read request, held until iwait=0
// iaddr      in   ADDR_W  instruction address
// iload      out  DATA_W  instruction data, valid when iwait=0
// iwait      out  1       1 = instruction request not complete
// dREN       in   1       data read request, held until dwait=0
// dWEN       in   1       data write request, held until dwait=0
// daddr      in   ADDR_W  data address
// dstore     in   DATA_W  write data
// dload      out  DATA_W  read data, valid when dwait=0
// dwait      out  1       1 = data request not complete
// ramREN     out  1       RAM read strobe
// ramWEN     out  1       RAM write strobe
// ramaddr    out  ADDR_W  RAM address
// ramstore   out  DATA_W  RAM write data
// ramload    in   DATA_W  RAM read data
// ram_ready  in   1       RAM access completes this cycle
// ram_error  in   1       RAM access faulted; qualified by ram_ready
// err_flag   out  1       sticky RAM error indicator
// BEHAVIOUR
// - States: IDLE, IACC, DACC. Reset (async, nRST=0): IDLE, starve_cnt=0, err_flag=0,
//   latched addr/data=0, ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0.
// - IDLE arbitration, evaluated every cycle:
//   - (dREN|dWEN) and starve_cnt<STARVE_MAX -> DACC;
//   - else iREN -> IACC; else stay in IDLE.
// - On grant, register the winner's addr (plus dstore and op for D). dREN&dWEN together = write.
// - IACC/DACC: ramaddr/ramstore/strobes driven only from latched registers. Requester changes after grant are ignored.
// - IACC: ramREN=1. DACC: ramREN=~op_wr, ramWEN=op_wr. IDLE: both strobes 0.
// - Completion: cycle with ram_ready=1 while in IACC/DACC.
//   - Owner's wait=0 for exactly that cycle; iload/dload=ramload (writes: dload=0).
//   - Next state is IDLE.
//   - Mandatory one-cycle turnaround in IDLE; min access = 2 cycles (grant+ready) plus 1 turnaround.
// - Wait outputs: wait=1 at all times outside the owner's completion cycle, including the non-owner during an access.
// - ram_error with ram_ready:
//   - access completes normally, but the returned load data is forced to 0;
//   - err_flag set, held until reset.
//   - ram_error without ram_ready is ignored.
// - starve_cnt, width clog2(STARVE_MAX+1):
//   - D grant while iREN=1: +1, saturating at STARVE_MAX;
//   - any I grant: cleared to 0;
//   - D grant with iREN=0: cleared to 0.
// - starve_cnt==STARVE_MAX and iREN=1 in IDLE: I wins even if D is requesting.
// - Reset mid-access: RAM strobes deassert asynchronously; the in-flight access is abandoned without a wait=0 pulse.
// - No combinational path from iREN/dREN/dWEN/addr to ram* outputs. wait/load depend combinationally on ram_ready/ramload only.
// TESTING
// - Reset: nRST=0 during DACC with ramWEN=1 -> ramWEN=0 same cycle, dwait=1, err_flag=0; after release state=IDLE.
// - Single I read: iREN=1, iaddr=0x40, ram_ready on 2nd access cycle with ramload=0x2402000A
//   -> iwait=0 that cycle only, iload=0x2402000A; ramREN low next cycle.
// - Simultaneous requests: iREN=1 and dREN=1 (daddr=0x80) in IDLE -> DACC first; dwait drops;
//   after turnaround, IACC with ramaddr=iaddr.
// - Starvation: iREN held, D requests continuous, STARVE_MAX=4 -> exactly 4 D grants, then an I grant; starve_cnt back to 0.
// - Write priority: dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dload=0 at completion.
// - Error: ram_ready=1 with ram_error=1 on an I read, ramload=0x1234 -> iload=0, iwait=0, err_flag=1 and stays 1 across later accesses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    input  logic              ram_error,
    output logic              err_flag
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic [CNT_W-1:0]   starve_cnt_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  store_r;
    logic               op_wr_r;
    logic               err_flag_r;
    logic               d_req_s;
    logic               grant_d_s;
    logic               grant_i_s;
    logic               done_s;

    // Arbitration, starvation bookkeeping and next-state selection
    always_comb begin
        d_req_s      = dREN | dWEN;
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        done_s       = 1'b0;
        state_s      = state_r;
        starve_cnt_s = starve_cnt_r;
        case (state_r)
            IDLE: begin
                // A saturated counter hands the port to a pending fetch even if data is asking
                if (d_req_s && ((starve_cnt_r < STARVE_LIM) || !iREN)) begin
                    grant_d_s = 1'b1;
                    state_s   = DACC;
                    if (!iREN) begin
                        starve_cnt_s = CNT_ZERO;
                    end else if (starve_cnt_r < STARVE_LIM) begin
                        starve_cnt_s = starve_cnt_r + CNT_ONE;
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end
                end else if (iREN) begin
                    grant_i_s    = 1'b1;
                    state_s      = IACC;
                    starve_cnt_s = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            IACC, DACC: begin
                if (ram_ready) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, sticky error and latched request registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= IDLE;
            starve_cnt_r <= CNT_ZERO;
            addr_r       <= {ADDR_W{1'b0}};
            store_r      <= {DATA_W{1'b0}};
            op_wr_r      <= 1'b0;
            err_flag_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
            err_flag_r   <= err_flag_r | (done_s & ram_error);
            if (grant_d_s) begin
                addr_r  <= daddr;
                store_r <= dstore;
                op_wr_r <= dWEN;
            end else if (grant_i_s) begin
                addr_r  <= iaddr;
            end
        end
    end

    // Completion handshake: only the owner sees wait drop, and only while ram_ready is high
    always_comb begin
        iwait = 1'b1;
        dwait = 1'b1;
        iload = {DATA_W{1'b0}};
        dload = {DATA_W{1'b0}};
        case (state_r)
            IACC: begin
                if (ram_ready) begin
                    iwait = 1'b0;
                    iload = ram_error ? {DATA_W{1'b0}} : ramload;
                end else begin
                    iwait = 1'b1;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    dwait = 1'b0;
                    dload = (ram_error || op_wr_r) ? {DATA_W{1'b0}} : ramload;
                end else begin
                    dwait = 1'b1;
                end
            end
            default: begin
                iwait = 1'b1;
                dwait = 1'b1;
            end
        endcase
    end

    // RAM side is a pure function of registered state so requester changes never leak through
    assign ramREN   = (state_r == IACC) || ((state_r == DACC) && !op_wr_r);
    assign ramWEN   = (state_r == DACC) && op_wr_r;
    assign ramaddr  = addr_r;
    assign ramstore = store_r;
    assign err_flag = err_flag_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: request/RAM driver with an arbitration model,
// plus a decoupled monitor that pops per-side expected load values.
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready, ram_error;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, err_flag;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .ram_error(ram_error),
        .err_flag(err_flag)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h2402_000A ^ {a[15:0], a[15:0]};
    endfunction

    function automatic bit faulty(input logic [31:0] a);
        return a[5:2] == 4'hF;
    endfunction

    // Monitor: every completion seen by a requester is checked against its queue
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (iREN && !iwait) begin
                if (i_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL i_resp: completion with no outstanding request at %0t", $time);
                end else begin
                    check("iload", iload, i_exp_q.pop_front());
                end
            end
            if ((dREN || dWEN) && !dwait) begin
                if (d_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL d_resp: completion with no outstanding request at %0t", $time);
                end else begin
                    check("dload", dload, d_exp_q.pop_front());
                end
            end
        end
    end

    // Requesters, RAM model and arbitration model
    bit          i_act, d_act, d_wr, d_both, d_old_valid;
    logic [31:0] i_req_addr, d_req_addr, d_req_store, d_old;
    int          owner, cnt, age, i_wait_cyc, d_wait_cyc;
    logic [31:0] own_addr;
    bit          prev_strobe, prev_ireq, prev_dreq, prev_complete;
    bit          strobe, complete, exp_d, err_exp, abort, do_rst, rst_done;
    logic        nx_iren, nx_dren, nx_dwen, nx_ready, nx_error;
    logic [31:0] nx_iaddr, nx_daddr, nx_dstore, nx_load;
    logic [31:0] dmem_ref [16];
    logic [31:0] ram_mem  [16];
    logic [3:0]  idx;
    int          r, i_prob, d_prob;

    task automatic clear_model();
        i_act = 1'b0; d_act = 1'b0; owner = 0; cnt = 0; age = 0;
        prev_strobe = 1'b0; prev_ireq = 1'b0; prev_dreq = 1'b0; prev_complete = 1'b0;
        err_exp = 1'b0;
        nx_iren = 1'b0; nx_dren = 1'b0; nx_dwen = 1'b0; nx_ready = 1'b0; nx_error = 1'b0;
        nx_iaddr = 32'd0; nx_daddr = 32'd0; nx_dstore = 32'd0; nx_load = 32'd0;
        i_exp_q.delete();
        d_exp_q.delete();
    endtask

    task automatic apply();
        iREN = nx_iren; iaddr = nx_iaddr;
        dREN = nx_dren; dWEN = nx_dwen; daddr = nx_daddr; dstore = nx_dstore;
        ram_ready = nx_ready; ram_error = nx_error; ramload = nx_load;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            dmem_ref[k] = 32'hC0DE_0000 + 32'(k);
            ram_mem[k]  = 32'hC0DE_0000 + 32'(k);
        end
        abort = 1'b0; do_rst = 1'b0; rst_done = 1'b0; d_old_valid = 1'b0;
        clear_model();
        nRST = 1'b0;
        apply();
        #2;
        check1("rst_iwait", iwait, 1'b1);
        check1("rst_dwait", dwait, 1'b1);
        check1("rst_ramREN", ramREN, 1'b0);
        check1("rst_ramWEN", ramWEN, 1'b0);
        check1("rst_err_flag", err_flag, 1'b0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        for (int cyc = 0; cyc < 4000 && !abort; cyc++) begin
            @(posedge CLK);
            #1;
            apply();
            if (do_rst) begin
                // Abandon an in-flight data write with an asynchronous reset
                check1("pre_rst_ramWEN", ramWEN, 1'b1);
                #2 nRST = 1'b0;
                #1;
                check1("mid_rst_ramWEN", ramWEN, 1'b0);
                check1("mid_rst_ramREN", ramREN, 1'b0);
                check1("mid_rst_dwait", dwait, 1'b1);
                check1("mid_rst_err_flag", err_flag, 1'b0);
                if (d_old_valid) dmem_ref[d_req_addr[5:2]] = d_old;
                clear_model();
                apply();
                @(negedge CLK);
                @(negedge CLK);
                nRST = 1'b1;
                do_rst = 1'b0;
                rst_done = 1'b1;
                continue;
            end
            @(negedge CLK);
            strobe   = ramREN | ramWEN;
            complete = strobe && ram_ready;
            check1("err_flag", err_flag, err_exp);
            if (prev_complete) begin
                check1("turnaround", strobe, 1'b0);
            end else if (!prev_strobe) begin
                if (prev_ireq || prev_dreq) begin
                    exp_d = prev_dreq && ((cnt < SMAX) || !prev_ireq);
                    check1("grant_strobe", strobe, 1'b1);
                    if (exp_d) begin
                        owner = 2; own_addr = d_req_addr;
                        check1("d_ramWEN", ramWEN, d_wr);
                        check1("d_ramREN", ramREN, !d_wr);
                        if (d_wr) check("ramstore", ramstore, d_req_store);
                        cnt = prev_ireq ? ((cnt < SMAX) ? cnt + 1 : cnt) : 0;
                    end else begin
                        owner = 1; own_addr = i_req_addr;
                        check1("i_ramREN", ramREN, 1'b1);
                        check1("i_ramWEN", ramWEN, 1'b0);
                        cnt = 0;
                    end
                    check("grant_addr", ramaddr, own_addr);
                end else begin
                    check1("idle_hold", strobe, 1'b0);
                end
            end else begin
                check1("hold_strobe", strobe, 1'b1);
                check("hold_addr", ramaddr, own_addr);
            end
            check1("iwait", iwait, !(complete && owner == 1));
            check1("dwait", dwait, !(complete && owner == 2));
            if (complete) begin
                if (ram_error) err_exp = 1'b1;
                if (ramWEN && !ram_error) ram_mem[ramaddr[5:2]] = ramstore;
            end
            if (i_act && !iwait) i_act = 1'b0;
            if (d_act && !dwait) begin d_act = 1'b0; d_old_valid = 1'b0; end
            if (i_act) i_wait_cyc++;
            if (d_act) d_wait_cyc++;
            if (i_wait_cyc > 80 || d_wait_cyc > 80) begin
                miscompares++;
                $display("FAIL timeout: request pending i=%0d d=%0d cycles, bound 80", i_wait_cyc, d_wait_cyc);
                abort = 1'b1;
            end

            // RAM model: ready no earlier than the second access cycle
            if (strobe && !complete) begin
                age++;
                if (age >= 4 || $urandom_range(0, 2) == 0) begin
                    nx_ready = 1'b1;
                    nx_error = faulty(ramaddr);
                    nx_load  = ramaddr[8] ? ram_mem[ramaddr[5:2]] : rom_word(ramaddr);
                end else begin
                    nx_ready = 1'b0;
                    nx_error = ($urandom_range(0, 7) == 0);
                    nx_load  = $urandom;
                end
            end else begin
                age = 0;
                nx_ready = 1'b0;
                nx_error = ($urandom_range(0, 7) == 0);
                nx_load  = $urandom;
            end

            i_prob = (cyc < 1500) ? 35 : 90;
            d_prob = (cyc < 1500) ? 35 : 95;
            if (cyc < 3600 && !i_act && $urandom_range(0, 99) < i_prob) begin
                r = ($urandom_range(0, 99) < 4) ? 15 : int'($urandom_range(0, 14));
                idx = 4'(r);
                i_req_addr = {25'd0, 1'($urandom_range(0, 1)), idx, 2'b00};
                i_exp_q.push_back(faulty(i_req_addr) ? 32'd0 : rom_word(i_req_addr));
                i_act = 1'b1; i_wait_cyc = 0; vectors++;
            end
            if (cyc < 3600 && !d_act && $urandom_range(0, 99) < d_prob) begin
                r = ($urandom_range(0, 99) < 4) ? 15 : int'($urandom_range(0, 14));
                idx = 4'(r);
                d_req_addr  = {23'd0, 1'b1, 2'b00, idx, 2'b00};
                d_req_store = $urandom;
                d_wr   = 1'($urandom_range(0, 1));
                d_both = 1'($urandom_range(0, 1));
                if (d_wr) begin
                    d_exp_q.push_back(32'd0);
                    d_old_valid = !faulty(d_req_addr);
                    d_old = dmem_ref[idx];
                    if (!faulty(d_req_addr)) dmem_ref[idx] = d_req_store;
                end else begin
                    d_exp_q.push_back(faulty(d_req_addr) ? 32'd0 : dmem_ref[idx]);
                end
                d_act = 1'b1; d_wait_cyc = 0; vectors++;
            end

            nx_iren  = i_act;
            nx_iaddr = (i_act && !(strobe && !complete && owner == 1)) ? i_req_addr : $urandom;
            nx_dren  = d_act && (!d_wr || d_both);
            nx_dwen  = d_act && d_wr;
            nx_daddr  = (d_act && !(strobe && !complete && owner == 2)) ? d_req_addr : $urandom;
            nx_dstore = (d_act && !(strobe && !complete && owner == 2)) ? d_req_store : $urandom;

            if (cyc >= 2400 && !rst_done && strobe && !complete && owner == 2 && d_wr && !nx_ready)
                do_rst = 1'b1;

            prev_strobe   = strobe;
            prev_complete = complete;
            prev_ireq     = iREN;
            prev_dreq     = dREN | dWEN;
        end

        check("drain_i", 32'(i_exp_q.size()), 32'd0);
        check("drain_d", 32'(d_exp_q.size()), 32'd0);
        check1("mid_reset_exercised", rst_done, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
